// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: responder state encoding, open-bus value,
// backend command payload and strobe decode helpers.
package z80_bus_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 16;

    localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_INTA = 2'd3
    } state_e;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bk_cmd_t;

    function automatic logic is_io_rd(input logic iorq_n, input logic m1_n, input logic rd_n);
        return !iorq_n && m1_n && !rd_n;
    endfunction

    function automatic logic is_io_wr(input logic iorq_n, input logic m1_n, input logic wr_n);
        return !iorq_n && m1_n && !wr_n;
    endfunction

    function automatic logic is_inta(input logic iorq_n, input logic m1_n);
        return !iorq_n && !m1_n;
    endfunction

endpackage

// File: rtl/z80_io_target_if.sv
// CPU strobe/data bus, backend req/ack channel and interrupt lines of the I/O responder.
interface z80_io_target_if;
    import z80_bus_pkg::*;

    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] dout;
    logic              m1_n;
    logic              iorq_n;
    logic              rd_n;
    logic              wr_n;
    logic              wait_n;
    logic              int_n;
    logic [DATA_W-1:0] di_out;
    logic              di_oe;

    logic              bk_req;
    logic              bk_we;
    logic [DATA_W-1:0] bk_addr;
    logic [DATA_W-1:0] bk_wdata;
    logic              bk_ack;
    logic [DATA_W-1:0] bk_rdata;

    logic              irq;
    logic              timeout_flag;

    modport master (
        output A, dout, m1_n, iorq_n, rd_n, wr_n, bk_ack, bk_rdata, irq,
        input  wait_n, int_n, di_out, di_oe, bk_req, bk_we, bk_addr, bk_wdata, timeout_flag
    );

    modport slave (
        input  A, dout, m1_n, iorq_n, rd_n, wr_n, bk_ack, bk_rdata, irq,
        output wait_n, int_n, di_out, di_oe, bk_req, bk_we, bk_addr, bk_wdata, timeout_flag
    );

endinterface

// File: rtl/z80_irq_latch.sv
// Single-source interrupt pending latch; a set in the same cycle as a clear keeps it pending.
module z80_irq_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic cen,
    input  logic set_i,
    input  logic clr_i,
    output logic int_n
);

    logic pending_q;
    logic pending_d;

    always_comb begin
        pending_d = pending_q;
        if (cen) begin
            if (set_i) begin
                pending_d = 1'b1;
            end else if (clr_i) begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign int_n = !pending_q;

endmodule

// File: rtl/z80_io_target.sv
// Z80 port-window responder: forwards I/O cycles to a slow req/ack backend,
// stretches the CPU with wait_n, and answers IM2 acknowledge with a fixed vector.
module z80_io_target
    import z80_bus_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE    = 8'h40,
    parameter logic [DATA_W-1:0] MASK    = 8'hF0,
    parameter int unsigned       TIMEOUT = 255,
    parameter logic [DATA_W-1:0] VECTOR  = 8'hE0
) (
    input logic            clk,
    input logic            reset_n,
    input logic            cen,
    z80_io_target_if.slave bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bk_req_q, bk_req_d;
    bk_cmd_t           cmd_q, cmd_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic              tmo_q, tmo_d;

    logic io_rd_c, io_wr_c, inta_c, io_hit_c, addr_hit_c, timeout_hit_c;
    logic int_n_c;
    logic unused_addr_hi;

    // Decodes are gated by reset so wait_n/di_oe release while reset is held.
    always_comb begin
        addr_hit_c    = ((bus.A[7:0] & MASK) == (BASE & MASK));
        io_rd_c       = is_io_rd(bus.iorq_n, bus.m1_n, bus.rd_n);
        io_wr_c       = is_io_wr(bus.iorq_n, bus.m1_n, bus.wr_n);
        io_hit_c      = reset_n && addr_hit_c && (io_rd_c || io_wr_c);
        inta_c        = reset_n && is_inta(bus.iorq_n, bus.m1_n);
        timeout_hit_c = (cnt_q >= TMO_LAST);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bk_req_d = bk_req_q;
        cmd_d    = cmd_q;
        di_d     = di_q;
        tmo_d    = tmo_q;
        if (cen) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (inta_c) begin
                        state_d = ST_INTA;
                    end else if (io_hit_c) begin
                        state_d    = ST_REQ;
                        bk_req_d   = 1'b1;
                        cmd_d.we   = io_wr_c;
                        cmd_d.addr = bus.A[7:0] & ~MASK;
                        if (io_wr_c) begin
                            cmd_d.wdata = bus.dout;
                        end
                        cnt_d = '0;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (bus.bk_ack) begin
                        state_d  = ST_DONE;
                        bk_req_d = 1'b0;
                        if (!cmd_q.we) begin
                            di_d = bus.bk_rdata;
                        end
                    end else if (timeout_hit_c) begin
                        state_d  = ST_DONE;
                        bk_req_d = 1'b0;
                        di_d     = OPEN_BUS;
                        tmo_d    = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.rd_n && bus.wr_n && bus.iorq_n) begin
                        state_d = ST_IDLE;
                        di_d    = OPEN_BUS;
                    end
                end
                ST_INTA: begin
                    if (bus.iorq_n) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bk_req_q <= 1'b0;
            cmd_q    <= '0;
            di_q     <= OPEN_BUS;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bk_req_q <= bk_req_d;
            cmd_q    <= cmd_d;
            di_q     <= di_d;
            tmo_q    <= tmo_d;
        end
    end

    z80_irq_latch u_irq_latch (
        .clk     (clk),
        .reset_n (reset_n),
        .cen     (cen),
        .set_i   (bus.irq),
        .clr_i   (state_q == ST_INTA),
        .int_n   (int_n_c)
    );

    assign bus.wait_n       = !(io_hit_c && (state_q == ST_IDLE || state_q == ST_REQ));
    assign bus.di_oe        = (reset_n && state_q == ST_DONE && !bus.rd_n && !bus.iorq_n) || inta_c;
    assign bus.di_out       = inta_c ? VECTOR : di_q;
    assign bus.int_n        = int_n_c;
    assign bus.bk_req       = bk_req_q;
    assign bus.bk_we        = cmd_q.we;
    assign bus.bk_addr      = cmd_q.addr;
    assign bus.bk_wdata     = cmd_q.wdata;
    assign bus.timeout_flag = tmo_q;

    assign unused_addr_hi = ^bus.A[15:8];

endmodule
